// File: rtl/raw2gray_pkg.sv
// Shared types and constants for the Bayer-RAW to greyscale converter.
package raw2gray_pkg;

    typedef enum logic [1:0] {RGGB = 2'd0, GRBG = 2'd1, GBRG = 2'd2, BGGR = 2'd3} bayer_e;
    typedef enum logic [1:0] {COL_R = 2'd0, COL_G0 = 2'd1, COL_G1 = 2'd2, COL_B = 2'd3} colour_e;
    typedef enum logic {MODE_AVG = 1'b0, MODE_LUMA = 1'b1} mode_e;

    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 75;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;

    // pos = {odd row, odd column} within the quad. Each phase is RGGB with
    // its column (bit 0) and/or row (bit 1) flipped, so an XOR does the mapping.
    function automatic colour_e posColour(bayer_e phase, logic [1:0] pos);
        return colour_e'(pos ^ phase);
    endfunction

    function automatic logic [7:0] lumaWeight(colour_e c);
        case (c)
            COL_R:   return 8'(LUMA_R);
            COL_B:   return 8'(LUMA_B);
            default: return 8'(LUMA_G);
        endcase
    endfunction

endpackage

// File: rtl/raw2gray_line_buf.sv
// One-line delay: each enabled cycle returns the sample written LINE_W enables ago.
module raw2gray_line_buf #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 1280
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEn,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oData
);
    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    logic [DATA_W-1:0] mem [LINE_W];
    logic [AW-1:0]     addr;

    // Read and write share the address; the read sees the old contents.
    assign oData = mem[addr];

    always_ff @(posedge iCLK) begin
        if (iEn)
            mem[addr] <= iData;
    end

    always_ff @(posedge iCLK) begin
        if (iRST)
            addr <= '0;
        else if (iEn)
            addr <= (addr == AW'(LINE_W - 1)) ? '0 : addr + AW'(1);
    end

endmodule

// File: rtl/raw2gray_pipe.sv
// Bayer-RAW 2x2 quad to grey converter, average or BT.601-style luma per frame.
// Optional frame min/max statistics when RAW2GRAY_STATS_EN is defined.
module raw2gray_pipe
    import raw2gray_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int LINE_W      = 1280,
    parameter int CNT_W       = 11,
    parameter int BAYER_PHASE = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic              iMODE,
    output logic [DATA_W-1:0] oGrey,
    output logic              oDVAL,
    output logic [CNT_W-2:0]  oX,
    output logic [CNT_W-2:0]  oY
`ifdef RAW2GRAY_STATS_EN
    ,
    output logic [DATA_W-1:0] oMin,
    output logic [DATA_W-1:0] oMax,
    output logic              oStatVld
`endif
);
    localparam int     ACC0_W = DATA_W + 2;
    localparam int     ACC1_W = DATA_W + LUMA_SHIFT;
    localparam bayer_e PHASE  = bayer_e'(2'(BAYER_PHASE));

    mode_e                   modeQ, s1Mode;
    logic [CNT_W-1:0]        xCnt, yCnt, curX, curY;
    logic                    quadDone;
    logic [1:0]              vldPipe;      // [0] window valid, [1] output valid
    logic [3:0][DATA_W-1:0]  win;          // {P(x,y), P(x-1,y), P(x,y-1), P(x-1,y-1)}
    logic [DATA_W-1:0]       lbOut;
    logic [CNT_W-2:0]        s1X, s1Y;
    logic [ACC0_W-1:0]       acc0;
    logic [ACC1_W-1:0]       acc1;
    logic [DATA_W-1:0]       greyNext;

    raw2gray_line_buf #(.DATA_W(DATA_W), .LINE_W(LINE_W)) uLineBuf (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEn   (iDVAL),
        .iData (iDATA),
        .oData (lbOut)
    );

    // Position of the pixel on iDATA this cycle; iSOF overrides to the origin.
    always_comb begin
        curX     = iSOF ? '0 : xCnt;
        curY     = iSOF ? '0 : yCnt;
        quadDone = iDVAL & curX[0] & curY[0];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xCnt  <= '0;
            yCnt  <= '0;
            modeQ <= MODE_AVG;
        end else begin
            if (iSOF)
                modeQ <= mode_e'(iMODE);
            if (iDVAL) begin
                if (curX == CNT_W'(LINE_W - 1)) begin
                    xCnt <= '0;
                    yCnt <= curY + CNT_W'(1);
                end else begin
                    xCnt <= curX + CNT_W'(1);
                    yCnt <= curY;
                end
            end else if (iSOF) begin
                xCnt <= '0;
                yCnt <= '0;
            end
        end
    end

    // Stage 1: window shift on every accepted pixel, quad tag on completion.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vldPipe <= '0;
            win     <= '0;
            s1X     <= '0;
            s1Y     <= '0;
            s1Mode  <= MODE_AVG;
        end else begin
            vldPipe <= {vldPipe[0], quadDone};
            if (iDVAL) begin
                win[3] <= iDATA;
                win[2] <= win[3];
                win[1] <= lbOut;
                win[0] <= win[1];
            end
            if (quadDone) begin
                s1X    <= curX[CNT_W-1:1];
                s1Y    <= curY[CNT_W-1:1];
                s1Mode <= modeQ;
            end
        end
    end

    // Weights are fixed by BAYER_PHASE, so the multiplies fold to constants.
    always_comb begin
        acc0 = '0;
        acc1 = '0;
        for (int i = 0; i < 4; i++) begin
            acc0 = acc0 + ACC0_W'(win[i]);
            acc1 = acc1 + ACC1_W'(lumaWeight(posColour(PHASE, 2'(i)))) * ACC1_W'(win[i]);
        end
        greyNext = (s1Mode == MODE_LUMA) ? acc1[ACC1_W-1:LUMA_SHIFT] : acc0[ACC0_W-1:2];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oGrey <= '0;
            oX    <= '0;
            oY    <= '0;
        end else if (vldPipe[0]) begin
            oGrey <= greyNext;
            oX    <= s1X;
            oY    <= s1Y;
        end
    end

    assign oDVAL = vldPipe[1];

`ifdef RAW2GRAY_STATS_EN
    logic [DATA_W-1:0] minQ, maxQ, minNext, maxNext;
    logic              seenQ, seenNext;

    // Fold in an output landing on the iSOF cycle before publishing.
    always_comb begin
        minNext  = (oDVAL && oGrey < minQ) ? oGrey : minQ;
        maxNext  = (oDVAL && oGrey > maxQ) ? oGrey : maxQ;
        seenNext = seenQ | oDVAL;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            minQ     <= '1;
            maxQ     <= '0;
            seenQ    <= 1'b0;
            oMin     <= '0;
            oMax     <= '0;
            oStatVld <= 1'b0;
        end else begin
            oStatVld <= 1'b0;
            if (iSOF) begin
                if (seenNext) begin
                    oMin     <= minNext;
                    oMax     <= maxNext;
                    oStatVld <= 1'b1;
                end
                minQ  <= '1;
                maxQ  <= '0;
                seenQ <= 1'b0;
            end else begin
                minQ  <= minNext;
                maxQ  <= maxNext;
                seenQ <= seenNext;
            end
        end
    end
`endif

endmodule

// File: tb/tb_raw2gray_pipe.sv
// Directed bench for raw2gray_pipe: an RGGB and a BGGR instance share one 4x4 stimulus stream.
module tb_raw2gray_pipe;
    localparam int DW = 12;
    localparam int LW = 4;
    localparam int CW = 4;

    logic iCLK = 1'b0;
    logic iRST, iDVAL, iSOF, iMODE;
    logic [DW-1:0] iDATA;

    logic [DW-1:0] aGrey, bGrey;
    logic          aDVAL, bDVAL;
    logic [CW-2:0] aX, aY, bX, bY;
`ifdef RAW2GRAY_STATS_EN
    logic [DW-1:0] aMin, aMax, bMin, bMax;
    logic          aStatVld, bStatVld;
`endif

    raw2gray_pipe #(.DATA_W(DW), .LINE_W(LW), .CNT_W(CW), .BAYER_PHASE(0)) dutA (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
        .oGrey(aGrey), .oDVAL(aDVAL), .oX(aX), .oY(aY)
`ifdef RAW2GRAY_STATS_EN
        , .oMin(aMin), .oMax(aMax), .oStatVld(aStatVld)
`endif
    );

    raw2gray_pipe #(.DATA_W(DW), .LINE_W(LW), .CNT_W(CW), .BAYER_PHASE(3)) dutB (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
        .oGrey(bGrey), .oDVAL(bDVAL), .oX(bX), .oY(bY)
`ifdef RAW2GRAY_STATS_EN
        , .oMin(bMin), .oMax(bMax), .oStatVld(bStatVld)
`endif
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {int g; int x; int y; int c;} ev_t;
    ev_t qA[$];
    ev_t qB[$];
    int  compCyc[$];
    int  nChk = 0;
    int  nFail = 0;
    logic [DW-1:0] frm [16];

    always @(negedge iCLK) begin
        if (aDVAL) qA.push_back('{int'(aGrey), int'(aX), int'(aY), cyc});
        if (bDVAL) qB.push_back('{int'(bGrey), int'(bX), int'(bY), cyc});
    end

    // Bayer layout: (even,even) gets ee, (odd,odd) gets oo, the rest get g.
    task automatic setBayer(input int ee, input int g, input int oo);
        for (int p = 0; p < 16; p++) begin
            if ((p % 2 == 0) && ((p / 4) % 2 == 0))      frm[p] = DW'(ee);
            else if ((p % 2 == 1) && ((p / 4) % 2 == 1)) frm[p] = DW'(oo);
            else                                         frm[p] = DW'(g);
        end
    endtask

    task automatic setQuads(input int v0, input int v1, input int v2, input int v3);
        int v [4];
        v = '{v0, v1, v2, v3};
        for (int p = 0; p < 16; p++)
            frm[p] = DW'(v[((p / 4) / 2) * 2 + (p % 4) / 2]);
    endtask

    task automatic sendFrame(input bit mode, input bit gaps, input bit sof);
        for (int p = 0; p < 16; p++) begin
            @(negedge iCLK);
            iDATA = frm[p]; iDVAL = 1'b1; iSOF = sof && (p == 0); iMODE = mode;
            if ((p % 2 == 1) && ((p / 4) % 2 == 1)) compCyc.push_back(cyc);
            if (gaps) begin
                @(negedge iCLK);
                iDVAL = 1'b0; iSOF = 1'b0;
            end
        end
        @(negedge iCLK);
        iDVAL = 1'b0; iSOF = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic clearQ();
        qA.delete(); qB.delete(); compCyc.delete();
    endtask

    task automatic test_reset();
        iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 1'b0; iDATA = '0;
        repeat (3) @(negedge iCLK);
        nChk++; if ({aDVAL, bDVAL} !== 2'b00) begin nFail++; $display("FAIL reset_dval got %b%b want 00", aDVAL, bDVAL); end
        nChk++; if (aGrey !== '0) begin nFail++; $display("FAIL reset_grey got %0d want 0", aGrey); end
        nChk++; if ({aX, aY} !== '0) begin nFail++; $display("FAIL reset_xy got %0d,%0d want 0,0", aX, aY); end
`ifdef RAW2GRAY_STATS_EN
        nChk++; if ({aMin, aMax, aStatVld} !== '0) begin nFail++; $display("FAIL reset_stats got %0d %0d %b want 0 0 0", aMin, aMax, aStatVld); end
`endif
        iRST = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_avg();
        clearQ();
        setBayer(100, 200, 40);
        sendFrame(1'b0, 1'b0, 1'b1);
        nChk++;
        if (qA.size() !== 4) begin nFail++; $display("FAIL avg_count got %0d want 4", qA.size()); end
        else for (int i = 0; i < 4; i++) begin
            nChk++;
            if (qA[i].g !== 135 || qA[i].x !== i % 2 || qA[i].y !== i / 2) begin
                nFail++; $display("FAIL avg_quad%0d got grey=%0d x=%0d y=%0d want 135 %0d %0d", i, qA[i].g, qA[i].x, qA[i].y, i % 2, i / 2);
            end
            nChk++;
            if (qA[i].c - compCyc[i] !== 2) begin nFail++; $display("FAIL avg_latency%0d got %0d want 2", i, qA[i].c - compCyc[i]); end
        end
        nChk++;
        if (qB.size() !== 4 || qB[0].g !== 135 || qB[3].g !== 135) begin
            nFail++; $display("FAIL avg_bggr_inst got n=%0d want 4 outputs of 135", qB.size());
        end
    endtask

    task automatic test_luma();
        clearQ();
        setBayer(100, 200, 40);
        sendFrame(1'b1, 1'b0, 1'b1);
        nChk++;
        if (qA.size() !== 4 || qB.size() !== 4) begin nFail++; $display("FAIL luma_count got %0d/%0d want 4/4", qA.size(), qB.size()); end
        else for (int i = 0; i < 4; i++) begin
            nChk++; if (qA[i].g !== 151) begin nFail++; $display("FAIL luma_rggb%0d got %0d want 151", i, qA[i].g); end
            nChk++; if (qB[i].g !== 140) begin nFail++; $display("FAIL luma_swapped%0d got %0d want 140", i, qB[i].g); end
        end
    endtask

    task automatic test_bggr();
        clearQ();
        setBayer(40, 200, 100);
        sendFrame(1'b1, 1'b0, 1'b1);
        nChk++;
        if (qA.size() !== 4 || qB.size() !== 4) begin nFail++; $display("FAIL bggr_count got %0d/%0d want 4/4", qA.size(), qB.size()); end
        else for (int i = 0; i < 4; i++) begin
            nChk++; if (qB[i].g !== 151) begin nFail++; $display("FAIL bggr_luma%0d got %0d want 151", i, qB[i].g); end
            nChk++; if (qA[i].g !== 140) begin nFail++; $display("FAIL bggr_swapped%0d got %0d want 140", i, qA[i].g); end
        end
        clearQ();
        sendFrame(1'b0, 1'b0, 1'b1);
        nChk++;
        if (qB.size() !== 4 || qB[1].g !== 135 || qB[2].g !== 135) begin
            nFail++; $display("FAIL bggr_avg got n=%0d want 4 outputs of 135", qB.size());
        end
    endtask

    task automatic test_gaps();
        clearQ();
        setBayer(100, 200, 40);
        sendFrame(1'b0, 1'b1, 1'b1);
        nChk++;
        if (qA.size() !== 4) begin nFail++; $display("FAIL gaps_count got %0d want 4", qA.size()); end
        else for (int i = 0; i < 4; i++) begin
            nChk++;
            if (qA[i].g !== 135 || qA[i].x !== i % 2 || qA[i].y !== i / 2) begin
                nFail++; $display("FAIL gaps_quad%0d got grey=%0d x=%0d y=%0d want 135 %0d %0d", i, qA[i].g, qA[i].x, qA[i].y, i % 2, i / 2);
            end
            nChk++;
            if (qA[i].c - compCyc[i] !== 2) begin nFail++; $display("FAIL gaps_latency%0d got %0d want 2", i, qA[i].c - compCyc[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clearQ();
        setBayer(100, 200, 40);
        for (int p = 0; p < 14; p++) begin
            @(negedge iCLK);
            iDATA = frm[p]; iDVAL = 1'b1; iSOF = (p == 0); iMODE = 1'b0;
        end
        // Pixel (1,3) just completed quad (0,1); reset must drop it.
        @(negedge iCLK);
        iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge iCLK);
            nChk++; if (aDVAL !== 1'b0) begin nFail++; $display("FAIL rstmid_dval%0d got %b want 0", k, aDVAL); end
        end
        iRST = 1'b0;
        nChk++; if (qA.size() !== 2) begin nFail++; $display("FAIL rstmid_count got %0d want 2", qA.size()); end
        clearQ();
        for (int p = 0; p < 16; p++) frm[p] = DW'(1000);
        sendFrame(1'b0, 1'b0, 1'b0);
        nChk++;
        if (qA.size() !== 4) begin nFail++; $display("FAIL rstmid_next_count got %0d want 4", qA.size()); end
        else if (qA[0].g !== 1000 || qA[0].x !== 0 || qA[0].y !== 0) begin
            nFail++; $display("FAIL rstmid_first got grey=%0d x=%0d y=%0d want 1000 0 0", qA[0].g, qA[0].x, qA[0].y);
        end
    endtask

`ifdef RAW2GRAY_STATS_EN
    task automatic test_stats();
        int pulses;
        clearQ();
        setQuads(10, 500, 37, 4095);
        sendFrame(1'b0, 1'b0, 1'b1);
        @(negedge iCLK);
        iSOF = 1'b1;
        @(negedge iCLK);
        iSOF = 1'b0;
        nChk++; if (aStatVld !== 1'b1) begin nFail++; $display("FAIL stats_vld got %b want 1", aStatVld); end
        nChk++; if (aMin !== DW'(10)) begin nFail++; $display("FAIL stats_min got %0d want 10", aMin); end
        nChk++; if (aMax !== DW'(4095)) begin nFail++; $display("FAIL stats_max got %0d want 4095", aMax); end
        pulses = 0;
        repeat (4) begin
            @(negedge iCLK);
            if (aStatVld) pulses++;
        end
        nChk++; if (pulses !== 0) begin nFail++; $display("FAIL stats_single_pulse got %0d extra want 0", pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_avg();
        test_luma();
        test_bggr();
        test_gaps();
        test_reset_mid();
`ifdef RAW2GRAY_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
